// File: rtl/button_debouncer_pkg.sv
// Shared debounce definitions: FSM state encoding and a counter-width helper.
//   db_state_e  : LOW=00, WAIT_HIGH=01, HIGH=11, WAIT_LOW=10
//   width_min1  : $clog2(n) clamped to at least one bit
package button_debouncer_pkg;

   typedef enum logic [1:0] {
      StLow      = 2'b00,
      StWaitHigh = 2'b01,
      StHigh     = 2'b11,
      StWaitLow  = 2'b10
   } db_state_e;

   localparam int unsigned MinSyncStages = 2;

   function automatic int unsigned width_min1(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/button_debouncer_if.sv
// Button debouncer signal bundle.
//   btn_in   : raw button level, asynchronous to clk
//   db_level : debounced, registered level
//   busy     : a candidate level change is being qualified
// master drives the raw button and observes the result; slave is the debouncer.
interface button_debouncer_if;

   logic btn_in;
   logic db_level;
   logic busy;

   modport master (
      output btn_in,
      input  db_level,
      input  busy
   );

   modport slave (
      input  btn_in,
      output db_level,
      output busy
   );

endinterface

// File: rtl/sample_tick_gen.sv
// Free-running prescaler producing a one-cycle sample tick every TICK_DIV clk cycles.
//   clk     : system clock
//   reset_n : asynchronous, active-low reset
//   tick    : high in the cycle the counter sits at TICK_DIV-1 (always high for TICK_DIV=1)
module sample_tick_gen
   import button_debouncer_pkg::*;
#(
   parameter int unsigned TICK_DIV = 50000
) (
   input  logic clk,
   input  logic reset_n,
   output logic tick
);

   localparam int unsigned     CntW    = width_min1(TICK_DIV);
   localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);

   logic [CntW-1:0] cnt_q;
   logic [CntW-1:0] cnt_d;

   assign tick = (cnt_q == CntLast);

   always_comb begin
      cnt_d = tick ? '0 : cnt_q + CntW'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/button_debouncer.sv
// Push-button conditioner: synchronises a raw button into clk and accepts a level change
// only after it has been stable for STABLE_TICKS sample ticks.
//   clk          : system clock
//   reset_n      : asynchronous, active-low reset
//   bus.btn_in   : raw button (async, active-high)
//   bus.db_level : debounced registered level, feeds the edge detector
//   bus.busy     : registered, high while the FSM is in a WAIT state
module button_debouncer
   import button_debouncer_pkg::*;
#(
   parameter int unsigned SYNC_STAGES  = 2,
   parameter int unsigned TICK_DIV     = 50000,
   parameter int unsigned STABLE_TICKS = 20
) (
   input  logic               clk,
   input  logic               reset_n,
   button_debouncer_if.slave  bus
);

   localparam int unsigned     CntW    = width_min1(STABLE_TICKS + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(STABLE_TICKS - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   btn_s;
   logic                   tick;

   db_state_e       state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            db_level_q, db_level_d;
   logic            busy_q, busy_d;

   // Synchroniser chain; the last stage is the only one the FSM looks at.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], bus.btn_in};
      end
   end

   assign btn_s = sync_q[SYNC_STAGES-1];

   sample_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (tick)
   );

   // Abort is tested before acceptance so a revert on the final tick wins.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      db_level_d = db_level_q;

      unique case (state_q)
         StLow: begin
            if (btn_s) begin
               state_d = StWaitHigh;
               cnt_d   = '0;
            end
         end
         StWaitHigh: begin
            if (!btn_s) begin
               state_d = StLow;
            end else if (tick) begin
               if (cnt_q == CntLast) begin
                  state_d    = StHigh;
                  db_level_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
         end
         StHigh: begin
            if (!btn_s) begin
               state_d = StWaitLow;
               cnt_d   = '0;
            end
         end
         StWaitLow: begin
            if (btn_s) begin
               state_d = StHigh;
            end else if (tick) begin
               if (cnt_q == CntLast) begin
                  state_d    = StLow;
                  db_level_d = 1'b0;
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
         end
         default: begin
            state_d = StLow;
         end
      endcase

      // Registered from the next state so busy tracks the state register exactly.
      busy_d = (state_d == StWaitHigh) || (state_d == StWaitLow);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StLow;
         cnt_q      <= '0;
         db_level_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         db_level_q <= db_level_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.db_level = db_level_q;
   assign bus.busy     = busy_q;

endmodule
